// File: rtl/bt_pipe_in_fifo.sv
// Receive FIFO behind the block-throttled pipe-in endpoint. It stores words,
// counts complete blocks, and raises ep_ready only when a whole unreserved block fits.
module bt_pipe_in_fifo #(
  parameter int DEPTH_LOG2 = 10,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  ti_clock,
  input  logic                  ti_reset,
  input  logic                  ep_write,
  input  logic                  ep_blockstrobe,
  input  logic [15:0]           ep_dataout,
  output logic                  ep_ready,
  input  logic                  rd_en,
  output logic [15:0]           rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           blocks_done,
  output logic                  overflow,
  output logic                  short_block
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   BS_C     = (DEPTH_LOG2+1)'(BLOCK_SIZE);
  localparam logic [DEPTH_LOG2+1:0] DEPTH_X  = (DEPTH_LOG2+2)'(DEPTH);
  localparam logic [DEPTH_LOG2+1:0] BS_X     = (DEPTH_LOG2+2)'(BLOCK_SIZE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RECV  = 2'd2;

  logic [15:0]         mem [0:DEPTH-1];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] cnt, cnt_n, cnt_c;
  logic [1:0]          state, state_n;
  logic [15:0]         blocks_n;
  logic                short_n;
  logic                full, wr_ok, rd_ok, open_c;
  logic [DEPTH_LOG2:0] level_n;
  logic [DEPTH_LOG2+1:0] pending_n;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LVL);
  assign rd_empty = (level == '0);
  assign wr_ok    = ep_write && !full;
  assign rd_ok    = rd_en && !rd_empty;

  // Strobe is applied before a same-cycle write so that write becomes word 0.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    blocks_n = blocks_done;
    short_n  = short_block;
    open_c   = (state != ST_IDLE);
    cnt_c    = cnt;
    if (ep_blockstrobe) begin
      if (open_c) short_n = 1'b1;
      open_c  = 1'b1;
      cnt_c   = '0;
      cnt_n   = '0;
      state_n = ST_ARMED;
    end
    if (ep_write) begin
      if (open_c) begin
        if (cnt_c + 1'b1 == BS_C) begin
          blocks_n = blocks_done + 16'd1;
          cnt_n    = '0;
          state_n  = ST_IDLE;
        end else begin
          cnt_n    = cnt_c + 1'b1;
          state_n  = ST_RECV;
        end
      end else begin
        short_n = 1'b1;
      end
    end
  end

  always_comb begin
    level_n   = level + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
    pending_n = '0;
    if (state_n != ST_IDLE) pending_n = BS_X - {1'b0, cnt_n};
  end

  always_ff @(posedge ti_clock) begin
    if (wr_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= ep_dataout;
  end

  always_ff @(posedge ti_clock) begin
    if (ti_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      state       <= ST_IDLE;
      blocks_done <= '0;
      overflow    <= 1'b0;
      short_block <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      ep_ready    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (ep_write && full) overflow <= 1'b1;
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      state       <= state_n;
      cnt         <= cnt_n;
      blocks_done <= blocks_n;
      short_block <= short_n;
      // Free space minus the reservation of the open block must cover a full block.
      ep_ready    <= ({1'b0, level_n} + pending_n + BS_X) <= DEPTH_X;
    end
  end

endmodule

// File: doc/bt_pipe_in_fifo.md
Name: bt_pipe_in_fifo

Overview:
User-side receive buffer that sits directly downstream of the block-throttled pipe-in endpoint (0x80–0x9F range).
- Consumes the endpoint's ep_write / ep_blockstrobe / ep_dataout stream and stores the words in a 16-bit FIFO.
- Drives ep_ready back to the endpoint only when a full block of space is free and not already reserved.
- Provides a 1-cycle-latency read port plus block accounting and sticky protocol-error flags for user logic.

Parameters:
DEPTH_LOG2, 10, FIFO depth is 2^DEPTH_LOG2 16-bit words.
BLOCK_SIZE, 256, words per host block; legal range is 1 to 2^DEPTH_LOG2.

Ports:
ti_clock  in  1  sole clock; all logic on its rising edge.
ti_reset  in  1  synchronous, active-high reset.
ep_write  in  1  word strobe from the pipe-in endpoint.
ep_blockstrobe  in  1  one-cycle pulse marking the start of a block.
ep_dataout  in  16  data word; valid when ep_write=1.
ep_ready  out  1  registered; 1 = space for one more full block.
rd_en  in  1  read request.
rd_data  out  16  read word; updates 1 cycle after an accepted rd_en.
rd_valid  out  1  1-cycle pulse qualifying rd_data.
rd_empty  out  1  level==0.
level  out  DEPTH_LOG2+1  stored word count.
blocks_done  out  16  count of completed blocks; wraps modulo 2^16.
overflow  out  1  sticky: a write arrived while the FIFO was full.
short_block  out  1  sticky: block protocol violation.

Behaviour:
- Storage and pointers:
  - Storage is a 2^DEPTH_LOG2 x 16 RAM.
  - wr_ptr and rd_ptr are DEPTH_LOG2+1 bits wide.
  - level = wr_ptr - rd_ptr, computed modulo 2^(DEPTH_LOG2+1).
  - full = (level == 2^DEPTH_LOG2).
  - full and empty are evaluated from the state at the start of the cycle. A same-cycle read does not free space for a same-cycle write.
- Reset (synchronous):
  - Clears wr_ptr, rd_ptr, the word counter, blocks_done, overflow, short_block, rd_data (0) and rd_valid (0).
  - Sets the state to IDLE and ep_ready to 0.
  - The cycle after reset deasserts, ep_ready = 1.
  - Reset mid-block discards all stored data and the partial block.
- Block FSM states:
  - IDLE: no block open.
  - ARMED: strobe seen, word counter = 0.
  - RECV: 1 to BLOCK_SIZE-1 words received.
- FSM transitions:
  - IDLE + ep_blockstrobe -> ARMED.
  - ARMED/RECV + ep_write -> word counter increments. On reaching BLOCK_SIZE: blocks_done+1, counter cleared, state -> IDLE. Otherwise state -> RECV.
  - ARMED/RECV + ep_blockstrobe -> short_block set, counter cleared, state -> ARMED. blocks_done is unchanged.
  - ep_blockstrobe and ep_write in the same cycle: the strobe is applied first, and the write counts as word 0 of the new block.
  - IDLE + ep_write (no strobe): the word is stored if not full, short_block is set, and the state stays IDLE.
  - BLOCK_SIZE==1: a strobe together with a write completes the block in that cycle.
- Write path:
  - ep_write with !full: RAM[wr_ptr] = ep_dataout and wr_ptr increments.
  - ep_write with full: the word is dropped, wr_ptr is held, and overflow is set. The word counter still advances so block framing stays aligned.
- Space reservation and ep_ready:
  - pending = BLOCK_SIZE - counter in ARMED/RECV, otherwise 0.
  - ep_ready is registered: ep_ready <= (2^DEPTH_LOG2 - level_next - pending_next) >= BLOCK_SIZE, where _next values include this cycle's write, read and FSM update.
  - ep_ready therefore reflects a strobe or read one cycle later.
- Read path:
  - rd_en with !rd_empty: rd_data <= RAM[rd_ptr], rd_ptr increments, and rd_valid = 1 on the next cycle.
  - rd_en with rd_empty: ignored, rd_valid = 0, rd_data held.
  - A simultaneous read and write while not full and not empty are both performed; level is unchanged.
- Sticky flags: overflow and short_block clear only on reset.

Test Plan (DEPTH_LOG2=4, BLOCK_SIZE=8):
1. Assert ti_reset for 2 cycles, then release -> during reset ep_ready=0, rd_valid=0, level=0. One cycle after release ep_ready=1, rd_empty=1, blocks_done=0.
2. Strobe, then write 0x1000–0x1007 over 8 cycles -> blocks_done=1, level=8, ep_ready stays 1. A second strobe -> ep_ready=0 on the cycle after it (16-8-8=0 free).
3. From step 2 (level=8), pulse rd_en for 8 cycles -> rd_data=0x1000..0x1007, each with rd_valid one cycle after its rd_en. rd_empty=1 after the last read, and ep_ready returns to 1.
4. Strobe, write 3 words, strobe again -> short_block=1 and blocks_done unchanged. Then 8 writes -> blocks_done increments by 1 and level=11.
5. After reset, send strobe+8, strobe+8 (16 words, full), then strobe with 1 write of 0xDEAD -> overflow=1 and level=16. Reading all 16 words never returns 0xDEAD.
6. Strobe, write 4 words, assert ti_reset for 1 cycle -> next cycle level=0, rd_empty=1, blocks_done=0, short_block=0. ep_ready=1 one cycle after reset, and a new full block then completes normally.
